// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM fader: channel count, default
// parameters, the per-channel derived state and the MAX helper.
package led_pkg;

    localparam int N_LED        = 4;
    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_PRESCALE = 25000;

    // Channel state is never stored; it is decoded from duty versus target.
    typedef enum logic [1:0] {
        CH_OFF,
        CH_RISE,
        CH_ON,
        CH_FALL
    } ch_state_e;

    // Full-scale duty value for a PWM counter of the given width.
    function automatic int pwm_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_pwm_fader_if.sv
// LED level/drive bundle between BLINK_LED-side logic and the fader.
interface led_pwm_fader_if;
    import led_pkg::*;

    logic [N_LED-1:0] LED_IN;
    logic             ENABLE;
    logic [N_LED-1:0] LED_OUT;
    logic             BUSY;

    modport master (output LED_IN, output ENABLE, input LED_OUT, input BUSY);
    modport slave  (input LED_IN, input ENABLE, output LED_OUT, output BUSY);

endinterface

// File: rtl/led_pwm_channel.sv
// One fader channel: duty register with saturating ramp toward the
// commanded level, plus the PWM compare that drives the LED pin.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                FAB_CLK,
    input  logic                FAB_RST,
    input  logic                tick,
    input  logic                target_bit,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(pwm_max(PWM_BITS));

    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_nxt;
    logic [PWM_BITS-1:0] target;
    ch_state_e           state;

    assign target = target_bit ? MAX : '0;

    // Decode the channel state from duty versus target.
    always_comb begin
        state = CH_OFF;
        if (duty < target) begin
            state = CH_RISE;
        end else if (duty > target) begin
            state = CH_FALL;
        end else if (target_bit) begin
            state = CH_ON;
        end
    end

    // Next duty: follow target in bypass, otherwise one step per tick.
    // Target is always 0 or MAX, so stepping toward it can never wrap.
    always_comb begin
        // NOTE: default assigned first so every path drives duty_nxt and no latch is inferred.
        duty_nxt = duty;
        if (!enable) begin
            duty_nxt = target;
        end else if (tick) begin
            case (state)
                CH_RISE: duty_nxt = duty + 1'b1;
                CH_FALL: duty_nxt = duty - 1'b1;
                default: duty_nxt = duty;
            endcase
        end
    end

    assign busy = enable && ((state == CH_RISE) || (state == CH_FALL));

    // Duty register and registered LED drive (PWM compare or bypass level).
    always_ff @(posedge FAB_CLK or posedge FAB_RST) begin
        if (FAB_RST) begin
            duty    <= '0;
            led_out <= 1'b0;
        end else begin
            // NOTE: non-blocking so duty and led_out both sample the pre-edge duty.
            duty    <= duty_nxt;
            led_out <= enable ? (duty > pwm_cnt) : target_bit;
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// Top of the LED PWM fader: input register, ramp prescaler, shared PWM
// counter, four fader channels and the registered BUSY summary.
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input logic            FAB_CLK,
    input logic            FAB_RST,
    led_pwm_fader_if.slave bus
);

    localparam int                  PRE_W    = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(pwm_max(PWM_BITS) - 1);

    logic [N_LED-1:0]    led_in_r;
    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic [N_LED-1:0]    led_out_w;
    logic [N_LED-1:0]    ch_busy;
    logic                busy_r;

    assign tick = (pre_cnt == PRE_LAST);

    // Register the commanded levels; everything downstream uses led_in_r.
    always_ff @(posedge FAB_CLK or posedge FAB_RST) begin
        if (FAB_RST) begin
            led_in_r <= '0;
        end else begin
            led_in_r <= bus.LED_IN;
        end
    end

    // Ramp prescaler: one tick every PRESCALE cycles, runs in bypass too.
    always_ff @(posedge FAB_CLK or posedge FAB_RST) begin
        if (FAB_RST) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // PWM counter 0..MAX-1 so duty MAX compares high on every cycle.
    always_ff @(posedge FAB_CLK or posedge FAB_RST) begin
        if (FAB_RST) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .FAB_CLK    (FAB_CLK),
            .FAB_RST    (FAB_RST),
            .tick       (tick),
            .target_bit (led_in_r[i]),
            .enable     (bus.ENABLE),
            .pwm_cnt    (pwm_cnt),
            .led_out    (led_out_w[i]),
            .busy       (ch_busy[i])
        );
    end

    // BUSY is the registered OR of the channel busy bits.
    always_ff @(posedge FAB_CLK or posedge FAB_RST) begin
        if (FAB_RST) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= |ch_busy;
        end
    end

    assign bus.LED_OUT = led_out_w;
    assign bus.BUSY    = busy_r;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader with PWM_BITS=4 (MAX=15) and PRESCALE=4.
// A cycle model built from time-since-reset arithmetic is compared with
// the DUT every cycle; directed literals pin both model and DUT.
module tb_led_pwm_fader;

    localparam int PWM_BITS = 4;
    localparam int PRESCALE = 4;
    localparam int MAX      = 15;

    logic FAB_CLK = 1'b0;
    logic FAB_RST = 1'b1;

    led_pwm_fader_if bus ();

    led_pwm_fader #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_dut (
        .FAB_CLK (FAB_CLK),
        .FAB_RST (FAB_RST),
        .bus     (bus)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Cycles since reset give the PWM phase and the ramp ticks directly.
    int         m_cyc;
    int         m_duty [4];
    logic [3:0] m_in_r;
    logic [3:0] m_led;
    logic       m_busy;
    int         m_pwm;
    bit         m_tick;
    int         m_tgt;
    logic [3:0] m_led_n;
    logic       m_busy_n;

    always @(posedge FAB_CLK or posedge FAB_RST) begin
        if (FAB_RST) begin
            m_cyc  = 0;
            m_in_r = 4'b0000;
            m_led  = 4'b0000;
            m_busy = 1'b0;
            for (int i = 0; i < 4; i++) m_duty[i] = 0;
        end else begin
            m_pwm    = m_cyc % MAX;
            m_tick   = ((m_cyc % PRESCALE) == PRESCALE - 1);
            m_busy_n = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_tgt = m_in_r[i] ? MAX : 0;
                if (bus.ENABLE) begin
                    m_led_n[i] = (m_duty[i] > m_pwm);
                    if (m_duty[i] != m_tgt) m_busy_n = 1'b1;
                    if (m_tick && m_duty[i] < m_tgt) m_duty[i] = m_duty[i] + 1;
                    else if (m_tick && m_duty[i] > m_tgt) m_duty[i] = m_duty[i] - 1;
                end else begin
                    m_led_n[i] = m_in_r[i];
                    m_duty[i]  = m_tgt;
                end
            end
            m_led  = m_led_n;
            m_busy = m_busy_n;
            m_in_r = bus.LED_IN;
            m_cyc  = m_cyc + 1;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(posedge FAB_CLK) begin
        #1;
        if (cmp_en) begin
            check("model_led_out", {28'd0, bus.LED_OUT}, {28'd0, m_led});
            check("model_busy", {31'd0, bus.BUSY}, {31'd0, m_busy});
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance n edges and sample 2 time units after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge FAB_CLK);
        #2;
    endtask

    // Hold reset for two cycles, then release on a falling edge.
    task automatic reset_release(input logic [3:0] led, input logic en);
        FAB_RST    = 1'b1;
        bus.LED_IN = led;
        bus.ENABLE = en;
        @(negedge FAB_CLK);
        @(negedge FAB_CLK);
        FAB_RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int drop;
    int peak;
    int max_jump;
    int prev;

    initial begin
        bus.LED_IN = 4'b0000;
        bus.ENABLE = 1'b0;
        #12;
        @(negedge FAB_CLK);
        FAB_RST = 1'b0;
        cmp_en  = 1'b1;

        // ---- 1: async reset with LED_IN=1111, then ramp from 0 ----
        bus.LED_IN = 4'b1111;
        step(3);
        check("bypass_before_reset", {28'd0, bus.LED_OUT}, 32'hF);
        FAB_RST    = 1'b1;
        bus.ENABLE = 1'b1;
        #1;
        check("async_reset_led_out", {28'd0, bus.LED_OUT}, 32'h0);
        check("async_reset_busy", {31'd0, bus.BUSY}, 32'h0);
        @(negedge FAB_CLK);
        FAB_RST = 1'b0;
        drop = 0;
        for (int k = 1; k <= 70; k++) begin
            step(1);
            if (k <= 15) check("pre_first_pulse", {28'd0, bus.LED_OUT}, 32'h0);
            else if (k <= 19) check("trace_high", {28'd0, bus.LED_OUT}, 32'hF);
            else if (k == 20) check("trace_low", {28'd0, bus.LED_OUT}, 32'h0);
            if (k == 1) check("busy_lag_1", {31'd0, bus.BUSY}, 32'h0);
            if (k == 2) check("busy_lag_2", {31'd0, bus.BUSY}, 32'h1);
            if (k > 2 && drop == 0 && !bus.BUSY) drop = k;
            if (drop != 0 && k > drop) check("full_on", {28'd0, bus.LED_OUT}, 32'hF);
        end
        check("full_ramp_busy_drop_edge", drop, 61);

        // ---- 2: rise ramp on channel 0 from an unaligned prescaler phase ----
        bus.ENABLE = 1'b0;
        bus.LED_IN = 4'b0000;
        step(3);
        bus.ENABLE = 1'b1;
        bus.LED_IN = 4'b0001;
        drop = 0;
        for (int k = 1; k <= 85; k++) begin
            step(1);
            if (k == 1) check("rise_busy_1", {31'd0, bus.BUSY}, 32'h0);
            if (k == 2) check("rise_busy_2", {31'd0, bus.BUSY}, 32'h1);
            if (k > 2 && drop == 0 && !bus.BUSY) drop = k;
            if (drop != 0 && k > drop) check("ch0_constant_on", {28'd0, bus.LED_OUT}, 32'h1);
        end
        n_tests++;
        if (drop < 59 || drop > 62) begin
            n_fail++;
            $display("FAIL rise_ramp_length: got %0d edges, expected 59..62", drop);
        end

        // ---- 4: reversal on channel 1 after 6 ticks ----
        reset_release(4'b0010, 1'b1);
        step(24);
        check("rev_model_peak_duty", m_duty[1], 6);
        bus.LED_IN = 4'b0000;
        peak = m_duty[1];
        prev = m_duty[1];
        max_jump = 0;
        drop = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (m_duty[1] > peak) peak = m_duty[1];
            if (m_duty[1] - prev > max_jump) max_jump = m_duty[1] - prev;
            if (prev - m_duty[1] > max_jump) max_jump = prev - m_duty[1];
            prev = m_duty[1];
            if (k == 4) check("rev_first_step", m_duty[1], 5);
            if (drop == 0 && !bus.BUSY) drop = k;
        end
        check("rev_peak", peak, 6);
        check("rev_max_jump", max_jump, 1);
        check("rev_final_duty", m_duty[1], 0);
        check("rev_busy_drop_edge", drop, 25);

        // ---- 5: bypass latency, then re-enable without a fade ----
        bus.ENABLE = 1'b0;
        bus.LED_IN = 4'b0000;
        step(3);
        bus.LED_IN = 4'b1010;
        step(1);
        check("bypass_lat_1", {28'd0, bus.LED_OUT}, 32'h0);
        step(1);
        check("bypass_lat_2", {28'd0, bus.LED_OUT}, 32'hA);
        check("bypass_busy", {31'd0, bus.BUSY}, 32'h0);
        bus.ENABLE = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            check("reenable_steady", {28'd0, bus.LED_OUT}, 32'hA);
            check("reenable_busy", {31'd0, bus.BUSY}, 32'h0);
        end

        // ---- 6: reset mid-ramp at duty 8, ramp restarts from 0 ----
        reset_release(4'b1111, 1'b1);
        step(32);
        check("mid_model_duty", m_duty[0], 8);
        check("mid_led_before_reset", {28'd0, bus.LED_OUT}, 32'hF);
        FAB_RST = 1'b1;
        #1;
        check("mid_reset_led_out", {28'd0, bus.LED_OUT}, 32'h0);
        check("mid_reset_busy", {31'd0, bus.BUSY}, 32'h0);
        check("mid_reset_model_duty", m_duty[0], 0);
        @(negedge FAB_CLK);
        @(negedge FAB_CLK);
        FAB_RST = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            if (k < 16) check("restart_low", {28'd0, bus.LED_OUT}, 32'h0);
            else check("restart_first_pulse", {28'd0, bus.LED_OUT}, 32'hF);
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
